// File: rtl/async_radicand_fork_tx_pkg.sv
// Shared types and helpers for the dual-rail radicand transmitter.
package pa_AsyncCordic;

    localparam int FW = 22;
    localparam int RW = FW + 7;

    typedef struct packed {
        logic t;
        logic f;
    } dual_rail_t;

    localparam dual_rail_t DR_SPACER = 2'b00;
    localparam dual_rail_t DR_ONE    = 2'b10;
    localparam dual_rail_t DR_ZERO   = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RTZ
    } tx_state_e;

    // Binary bit to dual-rail codeword; never produces spacer or 11.
    function automatic dual_rail_t dr_encode(input logic b);
        return b ? DR_ONE : DR_ZERO;
    endfunction

endpackage

// File: rtl/async_radicand_fork_tx_sync.sv
// Multi-flop synchronizer for one asynchronous ack line, reset to 0.
module async_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ack,
    output logic ack_sync
);

    logic [SYNC_STAGES-1:0] sr;

    // Shift the raw ack through the synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_sync = sr[SYNC_STAGES-1];

endmodule

// File: rtl/async_radicand_fork_tx.sv
// Four-phase dual-rail transmitter forking one radicand word into three
// channels (hiddenBit, fraction, accBits) with a C-element style ack join.
module async_radicand_fork_tx
    import pa_AsyncCordic::*;
#(
    parameter int FW          = 22,
    parameter int RW          = FW + 7,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [RW:0]          data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output dual_rail_t [1:0]     hiddenBit_o,
    output dual_rail_t [FW:0]    fraction_o,
    output dual_rail_t [4:0]     accBits_o,
    input  logic                 hiddenBit_ack,
    input  logic                 fraction_ack,
    input  logic                 accBits_ack,
    output logic                 err_o,
    output logic [CNT_W-1:0]     tx_count_o
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    tx_state_e         state;
    tx_state_e         state_n;
    logic              ahs;
    logic              fas;
    logic              aas;
    logic [2:0]        acks;
    logic [2:0]        acks_p;
    logic              all_hi;
    logic              all_lo;
    logic              accept;
    logic              ready_n;
    logic              err_n;
    logic [WARM_W-1:0] warm;
    logic              warm_done;

    async_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ahs (
        .clk_i(clk_i), .rst_i(rst_i), .ack(hiddenBit_ack), .ack_sync(ahs));
    async_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fas (
        .clk_i(clk_i), .rst_i(rst_i), .ack(fraction_ack), .ack_sync(fas));
    async_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_aas (
        .clk_i(clk_i), .rst_i(rst_i), .ack(accBits_ack), .ack_sync(aas));

    assign acks   = {ahs, fas, aas};
    assign all_hi = &acks;
    assign all_lo = ~|acks;
    assign accept = (state == IDLE) & valid_i & ready_o;

    // The synchronizers reset to 0, so all_lo is meaningless until they have
    // sampled the real ack lines; this keeps ready_o low after a reset taken
    // with stale acks still high.
    assign warm_done = (warm == WARM_W'(SYNC_STAGES));

    // Next-state, ready and protocol-violation decode.
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_n = DATA;
            end
            DATA: begin
                if (|(acks_p & ~acks)) err_n = 1'b1;
                if (all_hi) state_n = RTZ;
            end
            RTZ: begin
                if (|(~acks_p & acks)) err_n = 1'b1;
                if (all_lo) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE) & all_lo & warm_done;
    end

    // State, handshake bookkeeping and registered channel outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            ready_o     <= 1'b0;
            err_o       <= 1'b0;
            tx_count_o  <= '0;
            acks_p      <= '0;
            warm        <= '0;
            hiddenBit_o <= '0;
            fraction_o  <= '0;
            accBits_o   <= '0;
        end else begin
            state   <= state_n;
            ready_o <= ready_n;
            acks_p  <= acks;
            if (!warm_done) warm <= warm + 1'b1;
            if (err_n) err_o <= 1'b1;
            if (state == RTZ && all_lo) tx_count_o <= tx_count_o + 1'b1;
            if (accept) begin
                for (int unsigned i = 0; i < 2; i++)
                    hiddenBit_o[i] <= dr_encode(data_i[RW-1+i]);
                for (int unsigned i = 0; i <= FW; i++)
                    fraction_o[i] <= dr_encode(data_i[5+i]);
                for (int unsigned i = 0; i < 5; i++)
                    accBits_o[i] <= dr_encode(data_i[i]);
            end else if (state == DATA && all_hi) begin
                hiddenBit_o <= '0;
                fraction_o  <= '0;
                accBits_o   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_async_radicand_fork_tx.sv
// Directed bench for async_radicand_fork_tx (CNT_W=4 so the wrap is reachable).
module tb_async_radicand_fork_tx;
    import pa_AsyncCordic::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [29:0]       data;
    logic              valid;
    logic              ready;
    dual_rail_t [1:0]  hb;
    dual_rail_t [22:0] fr;
    dual_rail_t [4:0]  ac;
    logic              hb_ack;
    logic              fr_ack;
    logic              ac_ack;
    logic              err;
    logic [3:0]        cnt;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] FR_ZEROS = 64'h0000_1555_5555_5555;
    localparam logic [63:0] FR_ONES  = 64'h0000_2AAA_AAAA_AAAA;

    async_radicand_fork_tx #(.FW(22), .RW(29), .SYNC_STAGES(2), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready),
        .hiddenBit_o(hb), .fraction_o(fr), .accBits_o(ac),
        .hiddenBit_ack(hb_ack), .fraction_ack(fr_ack), .accBits_ack(ac_ack),
        .err_o(err), .tx_count_o(cnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(ready), 64'd1);
    endtask

    task automatic set_acks(input logic v);
        hb_ack = v;
        fr_ack = v;
        ac_ack = v;
    endtask

    task automatic check_spacer(input string tag);
        chk({tag, "_hb"}, 64'(hb), 64'd0);
        chk({tag, "_fr"}, 64'(fr), 64'd0);
        chk({tag, "_ac"}, 64'(ac), 64'd0);
    endtask

    // Accept one word and run a full handshake with prompt receivers.
    task automatic do_xfer(input logic [29:0] w);
        wait_ready("xfer_ready");
        data  = w;
        valid = 1'b1;
        cyc(1);
        valid = 1'b0;
        set_acks(1'b1);
        cyc(3);
        set_acks(1'b0);
        cyc(3);
    endtask

    initial begin
        rst   = 1'b1;
        data  = '0;
        valid = 1'b0;
        set_acks(1'b0);
        cyc(2);
        chk("rst_hb", 64'(hb), 64'd0);
        chk("rst_fr", 64'(fr), 64'd0);
        chk("rst_ac", 64'(ac), 64'd0);
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        rst = 1'b0;
        wait_ready("init_ready");

        // Basic transfer
        data  = 30'h2000_0001;
        valid = 1'b1;
        cyc(1);
        valid = 1'b0;
        chk("basic_hb", 64'(hb), 64'h9);
        chk("basic_ac", 64'(ac), 64'h156);
        chk("basic_fr", 64'(fr), FR_ZEROS);
        chk("basic_busy", 64'(ready), 64'd0);
        cyc(2);
        set_acks(1'b1);
        cyc(2);
        chk("basic_hold", 64'(hb), 64'h9);
        cyc(1);
        check_spacer("basic_sp");
        cyc(2);
        set_acks(1'b0);
        cyc(3);
        chk("basic_cnt", 64'(cnt), 64'd1);
        chk("basic_ready", 64'(ready), 64'd1);

        // Staggered acks
        data  = 30'h1234_5678;
        valid = 1'b1;
        cyc(1);
        valid = 1'b0;
        chk("stag_hb", 64'(hb), 64'h6);
        chk("stag_ac", 64'(ac), 64'h295);
        cyc(2);
        hb_ack = 1'b1;
        cyc(3);
        ac_ack = 1'b1;
        cyc(4);
        fr_ack = 1'b1;
        cyc(2);
        chk("stag_not_early", 64'(hb), 64'h6);
        cyc(1);
        check_spacer("stag_sp");
        chk("stag_err", 64'(err), 64'd0);
        set_acks(1'b0);
        cyc(3);
        chk("stag_cnt", 64'(cnt), 64'd2);

        // Back-pressure
        data  = 30'h3FFF_FFFF;
        valid = 1'b1;
        cyc(1);
        chk("bp1_hb", 64'(hb), 64'hA);
        chk("bp1_ac", 64'(ac), 64'h2AA);
        chk("bp1_fr", 64'(fr), FR_ONES);
        data = 30'h0;
        set_acks(1'b1);
        cyc(20);
        check_spacer("bp_hold_sp");
        chk("bp_hold_ready", 64'(ready), 64'd0);
        chk("bp_hold_cnt", 64'(cnt), 64'd2);
        set_acks(1'b0);
        cyc(3);
        chk("bp_cnt3", 64'(cnt), 64'd3);
        chk("bp_still_sp", 64'(hb), 64'd0);
        cyc(1);
        valid = 1'b0;
        chk("bp2_hb", 64'(hb), 64'h5);
        chk("bp2_ac", 64'(ac), 64'h155);
        chk("bp2_fr", 64'(fr), FR_ZEROS);
        set_acks(1'b1);
        cyc(3);
        check_spacer("bp2_sp");
        set_acks(1'b0);
        cyc(3);
        chk("bp_cnt4", 64'(cnt), 64'd4);
        chk("bp_err", 64'(err), 64'd0);

        // Protocol error: fraction ack glitches high in DATA
        data  = 30'h2000_0001;
        valid = 1'b1;
        cyc(1);
        valid = 1'b0;
        fr_ack = 1'b1;
        cyc(4);
        fr_ack = 1'b0;
        cyc(4);
        chk("perr_err", 64'(err), 64'd1);
        chk("perr_no_abort", 64'(hb), 64'h9);
        set_acks(1'b1);
        cyc(3);
        check_spacer("perr_sp");
        set_acks(1'b0);
        cyc(3);
        chk("perr_cnt", 64'(cnt), 64'd5);
        chk("perr_sticky", 64'(err), 64'd1);

        // Reset mid-transfer with acks high
        wait_ready("mid_ready");
        data  = 30'h3FFF_FFFF;
        valid = 1'b1;
        cyc(1);
        valid = 1'b0;
        chk("mid_hb", 64'(hb), 64'hA);
        set_acks(1'b1);
        cyc(1);
        rst = 1'b1;
        #1;
        check_spacer("mid_async_sp");
        chk("mid_err", 64'(err), 64'd0);
        chk("mid_cnt", 64'(cnt), 64'd0);
        cyc(1);
        rst = 1'b0;
        cyc(6);
        chk("mid_stale_ready", 64'(ready), 64'd0);
        chk("mid_stale_err", 64'(err), 64'd0);
        set_acks(1'b0);
        wait_ready("mid_ready_after");
        chk("mid_err_after", 64'(err), 64'd0);

        // Counter wrap at CNT_W=4
        for (int i = 1; i <= 17; i++) begin
            do_xfer(30'(i));
            if (i == 15) chk("wrap_15", 64'(cnt), 64'd15);
            if (i == 16) chk("wrap_0", 64'(cnt), 64'd0);
            if (i == 17) chk("wrap_1", 64'(cnt), 64'd1);
        end
        chk("wrap_err", 64'(err), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/async_radicand_fork_tx.md
Name: async_radicand_fork_tx

Overview:
- Clocked transmitter that drives the dual-rail radicand channels consumed by the operand/hidden-bit join stage. It is the sending end of that four-phase return-to-zero protocol.
- Accepts a bundled-data radicand word from the synchronous front end via valid/ready.
- Encodes the word to dual-rail and forks it into three channels: hiddenBit, fraction and accBits.
- Completes the handshake only when all three branch acks have risen, then falls through spacer.

Parameters:
- FW, 22: fraction MSB index; the fraction channel is FW+1 bits.
- RW, FW+7: radicand MSB index; the input word is RW+1 bits, split 2 + (FW+1) + 5.
- SYNC_STAGES, 2: flops per ack synchronizer, minimum 2.
- CNT_W, 16: width of the completed-transfer counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- data_i  in  RW+1  binary radicand; bits [RW:RW-1] hiddenBit, [RW-2:5] fraction, [4:0] accBits
- valid_i  in  1  data_i valid
- ready_o  out  1  transmitter can accept a word
- hiddenBit_o  out  pa_AsyncCordic::dual_rail_t[1:0]  dual-rail hiddenBit channel
- fraction_o  out  pa_AsyncCordic::dual_rail_t[FW:0]  dual-rail fraction channel
- accBits_o  out  pa_AsyncCordic::dual_rail_t[4:0]  dual-rail accBits channel
- hiddenBit_ack  in  1  async ack from hiddenBit receiver
- fraction_ack  in  1  async ack from fraction receiver
- accBits_ack  in  1  async ack from accBits receiver
- err_o  out  1  sticky protocol-violation flag
- tx_count_o  out  CNT_W  completed four-phase transfers, wraps modulo 2^CNT_W

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - all dual-rail outputs at spacer ({t,f}=00)
  - state IDLE
  - ready_o=0 until the first clock edge after reset release; ready_o is registered
  - err_o=0
  - tx_count_o=0
- Encoding: binary 1 -> {t,f}=10; binary 0 -> {t,f}=01. Spacer is 00; 11 is never driven. All channel outputs come straight from flops, with no combinational path to the pins.
- Acks pass through SYNC_STAGES-flop synchronizers (ahs/fas/aas). Derived signals:
  - all_hi = ahs & fas & aas
  - all_lo = ~(ahs | fas | aas)
- ready_o = (state==IDLE) & all_lo, registered from next-state.
- FSM:
  - IDLE: outputs spacer. On valid_i & ready_o, capture data_i into the codeword registers and go to DATA. The codeword is visible on the pins on the same edge, so latency is 1 cycle from the accept edge.
  - DATA: hold the codeword. When all_hi, drive spacer and go to RTZ. Partial acks wait; this is C-element join semantics across the three branches.
  - RTZ: hold spacer. When all_lo, increment tx_count_o and go to IDLE.
- Protocol checks, all setting err_o, which clears only on reset:
  - In DATA, any synced ack that was seen high then falls before all_hi. The FSM keeps waiting and does not abort.
  - In RTZ, any ack that was low rises again before all_lo.
- valid_i while ready_o=0 is held off, never dropped. data_i must stay stable until accepted.
- In IDLE with stale acks high (for example after a reset mid-transfer), ready_o stays 0 until all_lo. No err_o is raised.
- Reset asserted mid-DATA: outputs go to spacer immediately (asynchronously), the FSM goes to IDLE and the word is discarded.
- tx_count_o wraps from 2^CNT_W-1 to 0 with no flag.
- Minimum transfer time is 2*SYNC_STAGES+3 cycles with instantaneous receivers.

Decomposition:
- pa_AsyncCordic holds:
  - dual_rail_t (packed struct {logic t; logic f;})
  - constants DR_SPACER=2'b00, DR_ONE=2'b10, DR_ZERO=2'b01
  - FW and RW
  - the FSM state enum tx_state_e {IDLE, DATA, RTZ}
- The encode function dr_encode(bit) lives in pa_AsyncCordic.
- One sub-module, async_ack_sync (parameter SYNC_STAGES, async reset to 0), is instantiated three times.

Test Plan:
- Basic transfer:
  - Stimulus: data_i=30'h2000_0001, valid_i=1; all three acks rise 2 cycles after the codeword appears, and fall 2 cycles after spacer appears.
  - Required response: hiddenBit_o={10,01}; accBits_o={01,01,01,01,10}; fraction_o all 01; then spacer; tx_count_o=1; ready_o returns to 1.
- Staggered acks:
  - Stimulus: hiddenBit_ack rises at cycle 2, accBits_ack at 5, fraction_ack at 9.
  - Required response: spacer appears exactly SYNC_STAGES+1 cycles after fraction_ack rises, never earlier; err_o stays 0.
- Back-pressure:
  - Stimulus: valid_i held high with words 30'h3FFF_FFFF then 30'h0, while acks hold all-high for 20 cycles.
  - Required response: the second word is not accepted until RTZ completes; it emits hiddenBit_o={10,10} then {01,01}; tx_count_o=2.
- Protocol error:
  - Stimulus: in DATA, fraction_ack rises and then falls before accBits_ack rises.
  - Required response: err_o=1 and stays 1 after a later normal completion; the FSM still completes on all_hi/all_lo.
- Reset mid-transfer:
  - Stimulus: assert rst_i in DATA with acks high.
  - Required response: outputs go to spacer within the same cycle (asynchronously); after release, ready_o stays 0 until the acks drop, then goes to 1; err_o=0.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 transfers.
  - Required response: tx_count_o sequence ends 15, 0, 1.
